// File: rtl/hero_write_rx.sv
// Hero write receiver: turns gapped hero write cycles into a FIFO-buffered beat
// stream, replacing dropped transactions with a single abort terminator.
module hero_write_rx #(
    parameter int  FIFO_DEPTH = 4,
    parameter int  MAX_BEATS  = 16,
    localparam int HERO_WIDTH = 36,
    localparam int SUB_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [45:0]           hero_wr,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [HERO_WIDTH-1:0] out_dat,
    output logic [SUB_WIDTH-1:0]  out_sub,
    output logic                  out_last,
    output logic                  out_abort,
    output logic                  err_overflow,
    output logic                  err_protocol,
    output logic [15:0]           txn_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int BEAT_W  = $clog2(MAX_BEATS + 1);
    localparam int ENTRY_W = HERO_WIDTH + SUB_WIDTH + 2;

    // hero_wr layout (MSB first): cycle_type[1:0], wdat[35:0], sub[6:0], clk_en.
    // cycle_type 0 is IDLE; code 3 is unused and behaves like IDLE.
    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_TXN   = 2'd1,
        RX_ABORT = 2'd2,
        RX_DROP  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic                  abort;
        logic                  last;
        logic [SUB_WIDTH-1:0]  sub;
        logic [HERO_WIDTH-1:0] dat;
    } entry_t;

    rx_state_t           state_r, state_n_s;
    logic [BEAT_W-1:0]   beat_cnt_r, beat_cnt_n_s;
    logic                done_seen_r, done_seen_n_s;
    entry_t              mem_r [FIFO_DEPTH];
    entry_t              mem_n_s [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_r, wr_r, rd_n_s, wr_n_s;
    logic [CNT_W-1:0]    cnt_r, cnt_n_s;
    entry_t              head_n_s, out_head_r, push_entry_s;
    logic                out_vld_r, err_overflow_r, err_protocol_r;
    logic [15:0]         txn_cnt_r, drop_cnt_r;

    logic [1:0]             cycle_type_s;
    logic [HERO_WIDTH-1:0]  wdat_s;
    logic [SUB_WIDTH-1:0]   sub_s;
    logic                   clk_en_s;
    logic                   beat_s, done_s, pop_s, room_s, seen_s;
    logic                   push_s, drop_s, ovf_s, prot_s;

    assign cycle_type_s = hero_wr[45:44];
    assign wdat_s       = hero_wr[43:8];
    assign sub_s        = hero_wr[7:1];
    assign clk_en_s     = hero_wr[0];

    assign beat_s = clk_en_s && ((cycle_type_s == CT_VALID) || (cycle_type_s == CT_DONE));
    assign done_s = (cycle_type_s == CT_DONE);
    assign pop_s  = out_vld_r && out_rdy;
    // A full FIFO still has room when its head leaves in the same cycle.
    assign room_s = (cnt_r != CNT_W'(FIFO_DEPTH)) || pop_s;
    assign seen_s = done_seen_r || (beat_s && done_s);

    // Receive state machine decisions: what to push, drop or flag this cycle.
    always_comb begin
        state_n_s     = state_r;
        beat_cnt_n_s  = beat_cnt_r;
        done_seen_n_s = done_seen_r;
        push_s        = 1'b0;
        push_entry_s  = {ENTRY_W{1'b0}};
        drop_s        = 1'b0;
        ovf_s         = 1'b0;
        prot_s        = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (beat_s && !room_s) begin
                    drop_s    = 1'b1;
                    ovf_s     = 1'b1;
                    state_n_s = done_s ? RX_IDLE : RX_DROP;
                end else if (beat_s) begin
                    push_s       = 1'b1;
                    push_entry_s = '{abort: 1'b0, last: done_s, sub: sub_s, dat: wdat_s};
                    beat_cnt_n_s = done_s ? BEAT_W'(0) : BEAT_W'(1);
                    state_n_s    = done_s ? RX_IDLE : RX_TXN;
                end else begin
                    state_n_s = RX_IDLE;
                end
            end
            RX_TXN: begin
                if (beat_s && (beat_cnt_r == BEAT_W'(MAX_BEATS))) begin
                    drop_s        = 1'b1;
                    prot_s        = 1'b1;
                    done_seen_n_s = done_s;
                    beat_cnt_n_s  = BEAT_W'(0);
                    state_n_s     = RX_ABORT;
                end else if (beat_s && !room_s) begin
                    drop_s        = 1'b1;
                    ovf_s         = 1'b1;
                    done_seen_n_s = done_s;
                    beat_cnt_n_s  = BEAT_W'(0);
                    state_n_s     = RX_ABORT;
                end else if (beat_s) begin
                    push_s       = 1'b1;
                    push_entry_s = '{abort: 1'b0, last: done_s, sub: sub_s, dat: wdat_s};
                    beat_cnt_n_s = done_s ? BEAT_W'(0) : (beat_cnt_r + BEAT_W'(1));
                    state_n_s    = done_s ? RX_IDLE : RX_TXN;
                end else begin
                    state_n_s = RX_TXN;
                end
            end
            RX_ABORT: begin
                drop_s        = beat_s;
                done_seen_n_s = seen_s;
                if (room_s) begin
                    push_s       = 1'b1;
                    push_entry_s = '{abort: 1'b1, last: 1'b1, sub: {SUB_WIDTH{1'b0}},
                                     dat: {HERO_WIDTH{1'b0}}};
                    state_n_s    = seen_s ? RX_IDLE : RX_DROP;
                end else begin
                    state_n_s = RX_ABORT;
                end
            end
            RX_DROP: begin
                drop_s = beat_s;
                if (beat_s && done_s) begin
                    state_n_s = RX_IDLE;
                end else begin
                    state_n_s = RX_DROP;
                end
            end
            default: begin
                state_n_s = RX_IDLE;
            end
        endcase
    end

    // Next FIFO contents, pointers and the head entry presented after the edge.
    always_comb begin
        mem_n_s = mem_r;
        rd_n_s  = rd_r;
        wr_n_s  = wr_r;
        if (pop_s) begin
            rd_n_s = rd_r + PTR_W'(1);
        end else begin
            rd_n_s = rd_r;
        end
        if (push_s) begin
            mem_n_s[wr_r] = push_entry_s;
            wr_n_s        = wr_r + PTR_W'(1);
        end else begin
            wr_n_s = wr_r;
        end
        cnt_n_s = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
        if (cnt_n_s != CNT_W'(0)) begin
            head_n_s = mem_n_s[rd_n_s];
        end else begin
            head_n_s = {ENTRY_W{1'b0}};
        end
    end

    // State, FIFO storage, registered outputs and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RX_IDLE;
            beat_cnt_r     <= BEAT_W'(0);
            done_seen_r    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            rd_r           <= PTR_W'(0);
            wr_r           <= PTR_W'(0);
            cnt_r          <= CNT_W'(0);
            out_vld_r      <= 1'b0;
            out_head_r     <= {ENTRY_W{1'b0}};
            err_overflow_r <= 1'b0;
            err_protocol_r <= 1'b0;
            txn_cnt_r      <= 16'd0;
            drop_cnt_r     <= 16'd0;
        end else begin
            state_r        <= state_n_s;
            beat_cnt_r     <= beat_cnt_n_s;
            done_seen_r    <= done_seen_n_s;
            mem_r          <= mem_n_s;
            rd_r           <= rd_n_s;
            wr_r           <= wr_n_s;
            cnt_r          <= cnt_n_s;
            out_vld_r      <= (cnt_n_s != CNT_W'(0));
            out_head_r     <= head_n_s;
            err_overflow_r <= ovf_s;
            err_protocol_r <= prot_s;
            if (push_s && push_entry_s.last && !push_entry_s.abort) begin
                txn_cnt_r <= txn_cnt_r + 16'd1;
            end else begin
                txn_cnt_r <= txn_cnt_r;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign out_vld      = out_vld_r;
    assign out_dat      = out_head_r.dat;
    assign out_sub      = out_head_r.sub;
    assign out_last     = out_head_r.last;
    assign out_abort    = out_head_r.abort;
    assign err_overflow = err_overflow_r;
    assign err_protocol = err_protocol_r;
    assign txn_cnt      = txn_cnt_r;
    assign drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_hero_write_rx.sv
// Bench for hero_write_rx: directed scenarios plus a random run, all checked
// against a queue-based transaction model of the receiver.
module tb_hero_write_rx;

    localparam int DEPTH = 4;
    localparam int MAXB  = 16;

    logic        clk;
    logic        rst;
    logic [45:0] hero_wr;
    logic        out_vld, out_rdy, out_last, out_abort;
    logic [35:0] out_dat;
    logic [6:0]  out_sub;
    logic        err_overflow, err_protocol;
    logic [15:0] txn_cnt, drop_cnt;

    hero_write_rx #(.FIFO_DEPTH(DEPTH), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst), .hero_wr(hero_wr),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_sub(out_sub),
        .out_last(out_last), .out_abort(out_abort),
        .err_overflow(err_overflow), .err_protocol(err_protocol),
        .txn_cnt(txn_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expected FIFO contents as {abort,last,sub,dat} plus transaction bookkeeping.
    logic [44:0] q[$];
    bit          m_txn, m_abort, m_disc, m_seen;
    int          m_nb, m_drops;
    logic [15:0] m_txns;
    logic        e_ovf, e_prot;

    function automatic logic [45:0] mk(input logic [1:0] ct, input logic [35:0] d,
                                       input logic [6:0] s, input logic en);
        return {ct, d, s, en};
    endfunction

    function automatic logic [15:0] exp_drops();
        return (m_drops > 65535) ? 16'hFFFF : m_drops[15:0];
    endfunction

    task automatic model_step(input logic [45:0] hw, input logic rdy, input logic r);
        logic beat, isd, pop, room;
        beat  = hw[0] && (hw[45:44] == 2'd1 || hw[45:44] == 2'd2);
        isd   = (hw[45:44] == 2'd2);
        e_ovf = 1'b0;
        e_prot = 1'b0;
        if (r) begin
            q.delete();
            m_txn = 0; m_abort = 0; m_disc = 0; m_seen = 0;
            m_nb = 0; m_drops = 0; m_txns = 16'd0;
        end else begin
            pop  = (q.size() > 0) && rdy;
            room = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (m_abort) begin
                if (beat) begin
                    m_drops++;
                    m_seen = m_seen | isd;
                end
                if (room) begin
                    q.push_back({1'b1, 1'b1, 43'd0});
                    m_abort = 0;
                    m_disc  = !m_seen;
                end
            end else if (m_disc) begin
                if (beat) begin
                    m_drops++;
                    if (isd) m_disc = 0;
                end
            end else if (beat) begin
                if (m_txn && m_nb == MAXB) begin
                    e_prot = 1'b1; m_drops++;
                    m_abort = 1; m_seen = isd; m_txn = 0; m_nb = 0;
                end else if (!room) begin
                    e_ovf = 1'b1; m_drops++;
                    if (m_txn) begin
                        m_abort = 1; m_seen = isd; m_txn = 0; m_nb = 0;
                    end else begin
                        m_disc = !isd;
                    end
                end else begin
                    q.push_back({1'b0, isd, hw[7:1], hw[43:8]});
                    if (isd) begin
                        m_txn = 0; m_nb = 0; m_txns = m_txns + 16'd1;
                    end else begin
                        m_txn = 1; m_nb++;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic [45:0] hw, input logic rdy, input logic r);
        hero_wr = hw;
        out_rdy = rdy;
        rst     = r;
        model_step(hw, rdy, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(mk(2'd1, 36'hABC, 7'h11, 1'b1), 1'b0, 1'b1);
        cyc(mk(2'd2, 36'hDEF, 7'h22, 1'b1), 1'b1, 1'b1);
        n_checks++;
        if ({out_vld, err_overflow, err_protocol} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {out_vld, err_overflow, err_protocol});
        else n_pass++;
        n_checks++;
        if ({txn_cnt, drop_cnt} !== 32'd0) $display("FAIL reset_counters: got txn=%0d drop=%0d want 0/0", txn_cnt, drop_cnt);
        else n_pass++;
        n_checks++;
        if ({out_dat, out_sub, out_last, out_abort} !== 45'd0) $display("FAIL reset_outputs: got dat=%h sub=%h last=%b abort=%b want 0", out_dat, out_sub, out_last, out_abort);
        else n_pass++;
        cyc(mk(2'd0, 36'd0, 7'd0, 1'b0), 1'b0, 1'b0);
    endtask

    task automatic test_single_beat();
        cyc(mk(2'd2, 36'h123456789, 7'h5A, 1'b1), 1'b1, 1'b0);
        n_checks++;
        if ({out_vld, out_dat, out_sub, out_last, out_abort} !== {1'b1, 36'h123456789, 7'h5A, 1'b1, 1'b0})
            $display("FAIL single_beat: got vld=%b dat=%h sub=%h last=%b abort=%b want 1/123456789/5a/1/0", out_vld, out_dat, out_sub, out_last, out_abort);
        else n_pass++;
        n_checks++;
        if (txn_cnt !== 16'd1) $display("FAIL single_txn_cnt: got %0d want 1", txn_cnt);
        else n_pass++;
        cyc(mk(2'd0, 36'd0, 7'd0, 1'b1), 1'b1, 1'b0);
        n_checks++;
        if (out_vld !== 1'b0) $display("FAIL single_drain: got vld=%b want 0", out_vld);
        else n_pass++;
    endtask

    task automatic test_gapped();
        logic [45:0] seq [6];
        logic [35:0] got [$];
        logic        lasts [$];
        logic [15:0] base;
        base   = m_txns;
        seq[0] = mk(2'd1, 36'hA00000001, 7'h01, 1'b1);
        seq[1] = mk(2'd0, 36'hBAD000001, 7'h02, 1'b1);
        seq[2] = mk(2'd1, 36'hBAD000002, 7'h03, 1'b0);
        seq[3] = mk(2'd1, 36'hA00000002, 7'h04, 1'b1);
        seq[4] = mk(2'd2, 36'hA00000003, 7'h05, 1'b1);
        seq[5] = mk(2'd0, 36'd0, 7'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(seq[i], 1'b1, 1'b0);
            if (out_vld) begin
                got.push_back(out_dat);
                lasts.push_back(out_last);
            end
        end
        n_checks++;
        if (got.size() != 3) $display("FAIL gapped_count: got %0d beats want 3", got.size());
        else n_pass++;
        if (got.size() == 3) begin
            n_checks++;
            if ({got[0], got[1], got[2]} !== {36'hA00000001, 36'hA00000002, 36'hA00000003})
                $display("FAIL gapped_data: got %h %h %h want a00000001 a00000002 a00000003", got[0], got[1], got[2]);
            else n_pass++;
            n_checks++;
            if ({lasts[0], lasts[1], lasts[2]} !== 3'b001) $display("FAIL gapped_last: got %b want 001", {lasts[0], lasts[1], lasts[2]});
            else n_pass++;
        end
        n_checks++;
        if (txn_cnt !== base + 16'd1) $display("FAIL gapped_txn_cnt: got %0d want %0d", txn_cnt, base + 16'd1);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] base_drop;
        logic [37:0] got [$];
        base_drop = drop_cnt;
        for (int i = 1; i <= 6; i++) begin
            cyc(mk(2'd1, 36'(i) + 36'hC00000000, 7'h10, 1'b1), 1'b0, 1'b0);
            if (i == 4 || i == 5) begin
                n_checks++;
                if (err_overflow !== (i == 5)) $display("FAIL overflow_pulse_%0d: got %b want %b", i, err_overflow, (i == 5));
                else n_pass++;
            end
        end
        cyc(mk(2'd2, 36'hC000000FF, 7'h10, 1'b1), 1'b0, 1'b0);
        n_checks++;
        if (drop_cnt !== base_drop + 16'd3) $display("FAIL overflow_drop_cnt: got %0d want %0d", drop_cnt, base_drop + 16'd3);
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            if (out_vld) got.push_back({out_abort, out_last, out_dat});
            cyc(mk(2'd0, 36'd0, 7'd0, 1'b0), 1'b1, 1'b0);
        end
        n_checks++;
        if (got.size() != 5) $display("FAIL overflow_entries: got %0d want 5", got.size());
        else n_pass++;
        if (got.size() == 5) begin
            n_checks++;
            if ({got[0], got[3]} !== {2'b00, 36'hC00000001, 2'b00, 36'hC00000004})
                $display("FAIL overflow_data: got %h %h want first/fourth beats", got[0], got[3]);
            else n_pass++;
            n_checks++;
            if (got[4] !== {2'b11, 36'd0}) $display("FAIL overflow_abort_entry: got %h want %h", got[4], {2'b11, 36'd0});
            else n_pass++;
        end
    endtask

    task automatic test_full_pop();
        int n;
        for (int i = 1; i <= 4; i++) cyc(mk(2'd1, 36'hD00000000 + 36'(i), 7'h20, 1'b1), 1'b0, 1'b0);
        cyc(mk(2'd1, 36'hD00000005, 7'h20, 1'b1), 1'b1, 1'b0);
        n_checks++;
        if ({err_overflow, out_vld, out_dat} !== {1'b0, 1'b1, 36'hD00000002})
            $display("FAIL full_pop: got ovf=%b vld=%b dat=%h want 0/1/d00000002", err_overflow, out_vld, out_dat);
        else n_pass++;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_vld) n++;
            cyc(mk(2'd0, 36'd0, 7'd0, 1'b1), 1'b1, 1'b0);
        end
        n_checks++;
        if (n != 4) $display("FAIL full_pop_count: got %0d entries want 4", n);
        else n_pass++;
        cyc(mk(2'd2, 36'hD000000FF, 7'h20, 1'b1), 1'b1, 1'b0);
        cyc(mk(2'd0, 36'd0, 7'd0, 1'b0), 1'b1, 1'b0);
    endtask

    task automatic test_protocol();
        logic [15:0] base_drop;
        int ndata, nabort;
        base_drop = drop_cnt;
        ndata = 0;
        nabort = 0;
        for (int i = 1; i <= 17; i++) begin
            cyc(mk(2'd1, 36'hE00000000 + 36'(i), 7'h30, 1'b1), 1'b1, 1'b0);
            if (out_vld && !out_abort) ndata++;
            if (i == 16 || i == 17) begin
                n_checks++;
                if (err_protocol !== (i == 17)) $display("FAIL protocol_pulse_%0d: got %b want %b", i, err_protocol, (i == 17));
                else n_pass++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc((i == 1) ? mk(2'd2, 36'hE000000FF, 7'h30, 1'b1) : mk(2'd0, 36'd0, 7'd0, 1'b0), 1'b1, 1'b0);
            if (out_vld && out_abort && out_last) nabort++;
        end
        n_checks++;
        if ({ndata, nabort} !== {32'd16, 32'd1}) $display("FAIL protocol_entries: got data=%0d abort=%0d want 16/1", ndata, nabort);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== base_drop + 16'd2) $display("FAIL protocol_drop_cnt: got %0d want %0d", drop_cnt, base_drop + 16'd2);
        else n_pass++;
        cyc(mk(2'd2, 36'hE00000100, 7'h31, 1'b1), 1'b1, 1'b0);
        n_checks++;
        if ({out_vld, out_last, out_abort, out_dat} !== {3'b110, 36'hE00000100})
            $display("FAIL protocol_recover: got vld=%b last=%b abort=%b dat=%h want 1/1/0/e00000100", out_vld, out_last, out_abort, out_dat);
        else n_pass++;
        cyc(mk(2'd0, 36'd0, 7'd0, 1'b0), 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        cyc(mk(2'd1, 36'hF00000001, 7'h40, 1'b1), 1'b0, 1'b0);
        cyc(mk(2'd1, 36'hF00000002, 7'h40, 1'b1), 1'b0, 1'b0);
        cyc(mk(2'd2, 36'hF00000003, 7'h40, 1'b1), 1'b0, 1'b1);
        n_checks++;
        if ({out_vld, txn_cnt, drop_cnt} !== 33'd0) $display("FAIL reset_mid: got vld=%b txn=%0d drop=%0d want 0/0/0", out_vld, txn_cnt, drop_cnt);
        else n_pass++;
        cyc(mk(2'd2, 36'hF00000004, 7'h41, 1'b1), 1'b1, 1'b0);
        n_checks++;
        if ({out_vld, out_last, out_abort, out_dat, txn_cnt} !== {3'b110, 36'hF00000004, 16'd1})
            $display("FAIL reset_mid_new_txn: got vld=%b last=%b abort=%b dat=%h txn=%0d want 1/1/0/f00000004/1", out_vld, out_last, out_abort, out_dat, txn_cnt);
        else n_pass++;
        cyc(mk(2'd0, 36'd0, 7'd0, 1'b0), 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [63:0] r64;
        logic [1:0]  ct;
        logic        en, rdy, r;
        int          bias;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) bias = $urandom_range(0, 2);
            r64 = {$urandom(), $urandom()};
            ct  = (bias == 0 && $urandom_range(0, 19) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 5) != 0);
            rdy = (bias == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 299) == 0);
            cyc(mk(ct, r64[35:0], r64[42:36], en), rdy, r);
            n_checks++;
            if ({out_vld, err_overflow, err_protocol, txn_cnt, drop_cnt} !== {(q.size() > 0), e_ovf, e_prot, m_txns, exp_drops()})
                $display("FAIL rand_ctrl cycle %0d: got vld=%b ovf=%b prot=%b txn=%0d drop=%0d want %b/%b/%b/%0d/%0d",
                         i, out_vld, err_overflow, err_protocol, txn_cnt, drop_cnt, (q.size() > 0), e_ovf, e_prot, m_txns, exp_drops());
            else n_pass++;
            if (q.size() > 0) begin
                n_checks++;
                if ({out_abort, out_last, out_sub, out_dat} !== q[0])
                    $display("FAIL rand_head cycle %0d: got %h want %h", i, {out_abort, out_last, out_sub, out_dat}, q[0]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        hero_wr = 46'd0;
        out_rdy = 1'b0;
        test_reset();
        test_single_beat();
        test_gapped();
        test_overflow();
        test_full_pop();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hero_write_rx.md
HERO_WRITE_RX -- requirements
Module: hero_write_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning beat FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter MAX_BEATS, default 16, meaning max beats per transaction, DONE beat included.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset, synchronous, active-high.
REQ-005 SHALL have port hero_wr  in  46 (test_pkg_a::hero_write_t)  meaning incoming hero write cycle: cycle_type, wdat, another_type_reference, clk_en.
REQ-006 SHALL have port out_vld  out  1  meaning output beat valid.
REQ-007 SHALL have port out_rdy  in  1  meaning consumer accepts beat.
REQ-008 SHALL have port out_dat  out  HERO_WIDTH (36)  meaning beat data.
REQ-009 SHALL have port out_sub  out  7 (sub_def_t)  meaning beat sideband.
REQ-010 SHALL have port out_last  out  1  meaning final beat of transaction.
REQ-011 SHALL have port out_abort  out  1  meaning synthetic terminator of a dropped transaction; out_dat/out_sub zero.
REQ-012 SHALL have port err_overflow  out  1  meaning one-cycle pulse: beat lost to full FIFO.
REQ-013 SHALL have port err_protocol  out  1  meaning one-cycle pulse: MAX_BEATS exceeded.
REQ-014 SHALL have port txn_cnt  out  16  meaning completed transactions (last=1, abort=0 entries pushed), wraps.
REQ-015 SHALL have port drop_cnt  out  16  meaning beats discarded, saturates at 0xFFFF.

Function
REQ-016 SHALL treat a cycle as a beat only when clk_en=1 and cycle_type is VALID or DONE; clk_en=0 or IDLE is a no-op in every state.
REQ-017 SHALL be a state machine with states RX_IDLE, RX_TXN, RX_ABORT, RX_DROP.
REQ-018 RX_IDLE: VALID -> push (last=0), beat_cnt=1, go RX_TXN; DONE -> push (last=1), stay (single-beat transaction).
REQ-019 RX_TXN: VALID -> push, beat_cnt+1; DONE -> push last=1, go RX_IDLE; IDLE/clk_en=0 mid-transaction is a legal gap.
REQ-020 Protocol error: beat in RX_TXN with beat_cnt==MAX_BEATS -> beat discarded, err_protocol pulse, go RX_ABORT.
REQ-021 Overflow: beat when FIFO count==FIFO_DEPTH and no pop that cycle -> beat discarded, err_overflow pulse; from RX_TXN go RX_ABORT; from RX_IDLE go RX_DROP if VALID, stay RX_IDLE if DONE.
REQ-022 Full FIFO with simultaneous pop (out_vld&&out_rdy) SHALL accept the push; no overflow.
REQ-023 RX_ABORT: push abort entry (last=1, abort=1) on first cycle FIFO has space; then go RX_IDLE if DONE seen since entry (including entry cycle), else RX_DROP.
REQ-024 RX_DROP: all beats discarded; DONE -> RX_IDLE.
REQ-025 Every discarded beat (error beat, RX_ABORT, RX_DROP) SHALL increment drop_cnt.
REQ-026 Latency: beat pushed at edge N appears on out_vld after edge N (visible cycle N+1) when FIFO was empty; FIFO order preserved.
REQ-027 out_dat/out_sub/out_last/out_abort SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-028 Pop occurs exactly when out_vld&&out_rdy at a rising edge; out_rdy ignored when out_vld=0.
REQ-029 At most one push and one pop per cycle; FIFO count in 0..FIFO_DEPTH.

Reset
REQ-030 rst=1 at an edge SHALL set state RX_IDLE, FIFO empty, beat_cnt=0, out_vld=0, err_overflow=0, err_protocol=0, txn_cnt=0, drop_cnt=0, out_dat/out_sub/out_last/out_abort=0.
REQ-031 rst asserted mid-transaction SHALL discard FIFO contents and partial transaction without abort entry; hero_wr ignored while rst=1.

Verification
REQ-032 Single beat: DONE wdat=0x123456789, out_rdy=1 -> next cycle out_vld=1, out_dat=0x123456789, out_last=1; txn_cnt=1.
REQ-033 Gapped 3-beat: VALID,IDLE,clk_en=0 VALID,VALID,DONE -> exactly 3 beats out, last only on third; txn_cnt=1.
REQ-034 Overflow: out_rdy=0, 6 VALIDs then DONE -> 4 queued beats, err_overflow on 5th beat, abort entry after first pop with out_rdy=1, drop_cnt=3.
REQ-035 Full with pop: FIFO full, out_rdy=1, VALID -> beat accepted, no err_overflow, count stays 4.
REQ-036 Protocol: 17 VALIDs, MAX_BEATS=16 -> 16 beats, err_protocol on 17th, abort entry, DONE returns RX_IDLE; drop_cnt=2 (17th + DONE).
REQ-037 Reset mid-transaction: 2 VALIDs then rst -> out_vld=0, counters 0; subsequent DONE seen as new single-beat transaction.
